sb_ram_slave: RTL

- On-chip RAM responder (slave) for the shared OR'd system bus.
- Mastered by the JTAG debug BIU and other initiators; serves single and burst read/write transactions.
- Used as the bus-side emulated memory in JTAG read/write benches and as a small debug scratch RAM in the SoC.
- Drives all outputs to zero whenever it is not responding, so they can be OR'd onto the bus.

---
 rtl/sb_ram_slave_if.sv | 53 +++++
 rtl/sb_ram_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sb_ram_slave_if.sv
// ---------------------------------------------------------------------------
// sb_ram_slave_if
// Signal bundle for one slave port on the shared OR'd system bus.
// Member names are written from the slave's point of view (_i = into the
// slave, _o = out of the slave). The bus clock and reset are not part of
// the bundle.
//
// Members:
//   sb_begin_transaction_i  transaction start strobe
//   sb_end_transaction_i    end/abort strobe from the master
//   sb_read_n_write_i       1 = read, 0 = write (valid with begin)
//   sb_address_data_i[31:0] byte address with begin, write data otherwise
//   sb_byte_enables_i[3:0]  per-byte write enables
//   sb_burst_size_i[7:0]    word count minus 1 (valid with begin)
//   sb_data_valid_i         write beat valid
//   sb_busy_i               master stall for read beats
//   sb_address_data_o[31:0] read data, 0 when not driving
//   sb_data_valid_o         read beat valid
//   sb_end_transaction_o    one-cycle end strobe from the slave
//   sb_error_o              one-cycle error strobe
//
// Modports: slave (used by sb_ram_slave), master (used by initiators).
// ---------------------------------------------------------------------------
interface sb_ram_slave_if;
  logic        sb_begin_transaction_i;
  logic        sb_end_transaction_i;
  logic        sb_read_n_write_i;
  logic [31:0] sb_address_data_i;
  logic [3:0]  sb_byte_enables_i;
  logic [7:0]  sb_burst_size_i;
  logic        sb_data_valid_i;
  logic        sb_busy_i;
  logic [31:0] sb_address_data_o;
  logic        sb_data_valid_o;
  logic        sb_end_transaction_o;
  logic        sb_error_o;

  modport slave (
    input  sb_begin_transaction_i, sb_end_transaction_i, sb_read_n_write_i,
           sb_address_data_i, sb_byte_enables_i, sb_burst_size_i,
           sb_data_valid_i, sb_busy_i,
    output sb_address_data_o, sb_data_valid_o, sb_end_transaction_o,
           sb_error_o
  );

  modport master (
    output sb_begin_transaction_i, sb_end_transaction_i, sb_read_n_write_i,
           sb_address_data_i, sb_byte_enables_i, sb_burst_size_i,
           sb_data_valid_i, sb_busy_i,
    input  sb_address_data_o, sb_data_valid_o, sb_end_transaction_o,
           sb_error_o
  );
endinterface

// File: rtl/sb_ram_slave.sv
// ---------------------------------------------------------------------------
// sb_ram_slave
// On-chip RAM responder for the shared OR'd system bus. Serves single and
// burst reads/writes into a window of 2^ADDR_BITS 32-bit words located at
// BASE_ADDR. Every output is 0 whenever the slave is not responding, so the
// outputs can be OR'd onto the bus with other slaves.
//
// Ports:
//   sb_clock_i  bus clock (single domain)
//   sb_reset_i  asynchronous active-high reset; RAM contents are kept
//   bus         sb_ram_slave_if.slave bundle (see sb_ram_slave_if.sv)
//
// Parameters:
//   BASE_ADDR    byte base address of the window, aligned to window size
//   ADDR_BITS    word-address width
//   WAIT_CYCLES  extra read wait states before the first read beat
//
// Build option:
//   SB_RAM_WAIT_STATES_EN  when defined, reads pass through RD_WAIT for
//                          WAIT_CYCLES cycles before the first beat; when
//                          undefined, the first beat follows RD_ADDR.
// ---------------------------------------------------------------------------
module sb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           sb_clock_i,
  input logic           sb_reset_i,
  sb_ram_slave_if.slave bus
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

`ifdef SB_RAM_WAIT_STATES_EN
  typedef enum logic [2:0] {IDLE, ERR, RD_ADDR, RD_WAIT, RD_DATA, WR, END} state_e;
`else
  typedef enum logic [2:0] {IDLE, ERR, RD_ADDR, RD_DATA, WR, END} state_e;
`endif

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           burst_q, burst_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [31:0]          rdData_q;
  logic [31:0]          mem_q [Depth];

  logic                 selected;
  logic                 outOfRange;
  logic                 lastBeat;
  logic                 ramRdEn;
  logic                 ramWrEn;
  logic [ADDR_BITS-1:0] startWord;

`ifdef SB_RAM_WAIT_STATES_EN
  logic [7:0]           waitCnt_q, waitCnt_d;
`else
  // WAIT_CYCLES has no effect without wait states; tie it off explicitly.
  logic                 unusedWaitCycles;
  assign unusedWaitCycles = ^32'(WAIT_CYCLES);
`endif

  assign selected   = bus.sb_begin_transaction_i &&
                      (bus.sb_address_data_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign startWord  = bus.sb_address_data_i[ADDR_BITS+1:2];
  assign outOfRange = (32'(startWord) + 32'(bus.sb_burst_size_i)) > 32'(Depth - 1);
  // cnt_q counts beats already transferred; 9 bits so a 256-beat write
  // can count past the last beat without wrapping.
  assign lastBeat   = (cnt_q == {1'b0, burst_q});

  // Next-state and RAM control. addr_q always holds the next word to be
  // read or written.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    ramRdEn = 1'b0;
    ramWrEn = 1'b0;
`ifdef SB_RAM_WAIT_STATES_EN
    waitCnt_d = waitCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (selected) begin
          addr_d  = startWord;
          burst_d = bus.sb_burst_size_i;
          cnt_d   = '0;
          if (outOfRange)                 state_d = ERR;
          else if (bus.sb_read_n_write_i) state_d = RD_ADDR;
          else                            state_d = WR;
        end
      end
      ERR: state_d = IDLE;
      RD_ADDR: begin
        ramRdEn = 1'b1;
        addr_d  = addr_q + 1'b1;
`ifdef SB_RAM_WAIT_STATES_EN
        waitCnt_d = '0;
        if (WAIT_CYCLES == 0) state_d = RD_DATA;
        else                  state_d = RD_WAIT;
`else
        state_d = RD_DATA;
`endif
        if (bus.sb_end_transaction_i) state_d = IDLE;
      end
`ifdef SB_RAM_WAIT_STATES_EN
      RD_WAIT: begin
        if (bus.sb_end_transaction_i)               state_d = IDLE;
        else if (waitCnt_q == 8'(WAIT_CYCLES - 1)) state_d = RD_DATA;
        else                                        waitCnt_d = waitCnt_q + 1'b1;
      end
`endif
      RD_DATA: begin
        if (bus.sb_end_transaction_i) begin
          state_d = IDLE;
        end else if (!bus.sb_busy_i) begin
          if (lastBeat) begin
            state_d = END;
          end else begin
            // Prefetch the following word so beats run back-to-back.
            ramRdEn = 1'b1;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      WR: begin
        if (bus.sb_data_valid_i && (cnt_q <= {1'b0, burst_q})) begin
          ramWrEn = 1'b1;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
        if (bus.sb_end_transaction_i) state_d = IDLE;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
    if (sb_reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
`ifdef SB_RAM_WAIT_STATES_EN
      waitCnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
`ifdef SB_RAM_WAIT_STATES_EN
      waitCnt_q <= waitCnt_d;
`endif
    end
  end

  // RAM array and its read register carry no reset so contents survive it.
  always_ff @(posedge sb_clock_i) begin
    if (ramWrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sb_byte_enables_i[b]) begin
          mem_q[addr_q][8*b +: 8] <= bus.sb_address_data_i[8*b +: 8];
        end
      end
    end
    if (ramRdEn) rdData_q <= mem_q[addr_q];
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign bus.sb_data_valid_o      = (state_q == RD_DATA);
  assign bus.sb_address_data_o    = (state_q == RD_DATA) ? rdData_q : '0;
  assign bus.sb_end_transaction_o = (state_q == END) || (state_q == ERR);
  assign bus.sb_error_o           = (state_q == ERR);

endmodule
